// File: rtl/audio_i2s_rx.sv
// I2S slave receiver: oversamples BCK/WS/DIN in the clk domain and emits 16-bit stereo frames on valid/ready.
// Define AUDIO_RX_FIFO_EN for a FIFO_DEPTH-entry frame FIFO; otherwise a single holding register is used.
module audio_i2s_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ADC_BCK,
    input  logic        ADC_WS,
    input  logic        ADC_DIN,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_left,
    output logic [15:0] out_right,
    output logic        locked,
    output logic        ovf
);
    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    logic [1:0]  bck_sync_q, bck_sync_d, ws_sync_q, ws_sync_d, din_sync_q, din_sync_d;
    logic        bck_prev_q, bck_prev_d, ws_prev_q, ws_prev_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] word_q, word_d, left_q, left_d;
    logic [7:0]  idle_q, idle_d;
    state_t      state_q, state_d;
    logic        locked_q, locked_d, ovf_q, ovf_d;

    logic        bck_rise, ws_change, timeout, push, push_ok, pop, full;
    logic [15:0] word_fin;
    logic [31:0] push_data;

    always_comb begin
        bck_sync_d = {bck_sync_q[0], ADC_BCK};
        ws_sync_d  = {ws_sync_q[0], ADC_WS};
        din_sync_d = {din_sync_q[0], ADC_DIN};
        bck_prev_d = bck_sync_q[1];

        bck_rise  = bck_sync_q[1] & ~bck_prev_q;
        ws_change = bck_rise && (ws_sync_q[1] != ws_prev_q);
        timeout   = !bck_rise && (idle_q == 8'hFF);
        ws_prev_d = bck_rise ? ws_sync_q[1] : ws_prev_q;
        idle_d    = bck_rise ? 8'd0 : ((idle_q == 8'hFF) ? idle_q : idle_q + 8'd1);

        // Bits land at position 15-bit_cnt, so short words come out left-justified and zero-padded.
        word_fin = word_q;
        if (bit_cnt_q < 5'd16) begin
            word_fin[4'd15 - bit_cnt_q[3:0]] = din_sync_q[1];
        end

        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        if (bck_rise) begin
            if (ws_change) begin
                bit_cnt_d = 5'd0;
                word_d    = 16'd0;
            end else begin
                word_d = word_fin;
                if (bit_cnt_q < 5'd16) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
        end

        state_d   = state_q;
        left_d    = left_q;
        push      = 1'b0;
        push_data = {left_q, word_fin};
        if (timeout) begin
            state_d = HUNT;
        end else if (ws_change) begin
            case (state_q)
                HUNT: begin
                    if (!ws_sync_q[1]) state_d = LEFT;
                end
                LEFT: begin
                    if (ws_sync_q[1]) begin
                        left_d  = word_fin;
                        state_d = RIGHT;
                    end
                end
                RIGHT: begin
                    if (!ws_sync_q[1]) begin
                        push    = 1'b1;
                        state_d = LEFT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        locked_d = (state_d != HUNT);
        ovf_d    = ovf_q | (push & ~push_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync_q <= '0;
            ws_sync_q  <= '0;
            din_sync_q <= '0;
            bck_prev_q <= 1'b0;
            ws_prev_q  <= 1'b0;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            left_q     <= '0;
            idle_q     <= '0;
            state_q    <= HUNT;
            locked_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            bck_sync_q <= bck_sync_d;
            ws_sync_q  <= ws_sync_d;
            din_sync_q <= din_sync_d;
            bck_prev_q <= bck_prev_d;
            ws_prev_q  <= ws_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            word_q     <= word_d;
            left_q     <= left_d;
            idle_q     <= idle_d;
            state_q    <= state_d;
            locked_q   <= locked_d;
            ovf_q      <= ovf_d;
        end
    end

    assign locked = locked_q;
    assign ovf    = ovf_q;

`ifdef AUDIO_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [31:0] mem_q [FIFO_DEPTH];
    logic [31:0] mem_d [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // A pop in the same cycle frees the slot the push needs, so full only blocks when nothing leaves.
    always_comb begin
        full      = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
        out_valid = (wr_ptr_q != rd_ptr_q);
        pop       = out_valid && out_ready;
        push_ok   = push && (!full || pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
    end

    assign {out_left, out_right} = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    localparam int unused_fifo_depth = FIFO_DEPTH;

    logic        valid_q, valid_d;
    logic [31:0] hold_q, hold_d;

    always_comb begin
        full    = valid_q;
        pop     = valid_q && out_ready;
        push_ok = push && (!full || pop);
        valid_d = push_ok ? 1'b1 : (pop ? 1'b0 : valid_q);
        hold_d  = push_ok ? push_data : hold_q;
    end

    assign out_valid             = valid_q;
    assign {out_left, out_right} = hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end
`endif

endmodule

// File: tb/tb_audio_i2s_rx.sv
// Self-checking bench for audio_i2s_rx: random I2S streams against a word-level frame model.
module tb_audio_i2s_rx;

`ifdef AUDIO_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ADC_BCK = 1'b0;
    logic        ADC_WS = 1'b0;
    logic        ADC_DIN = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid, locked, ovf;
    logic [15:0] out_left, out_right;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        int          nl;
        int          nr;
    } frame_t;

    frame_t      tx_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        last_bit = 1'b0;

    always #5 clk = ~clk;

    audio_i2s_rx #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ADC_BCK   (ADC_BCK),
        .ADC_WS    (ADC_WS),
        .ADC_DIN   (ADC_DIN),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_left  (out_left),
        .out_right (out_right),
        .locked    (locked),
        .ovf       (ovf)
    );

    // Reference: an N-bit word becomes its top 16 bits, or is padded with zeros below if shorter.
    function automatic logic [15:0] exp_word(input logic [31:0] val, input int n);
        logic [63:0] v;
        v = {32'b0, val} & ((64'd1 << n) - 64'd1);
        if (n >= 16) return 16'(v >> (n - 16));
        return 16'(v << (16 - n));
    endfunction

    task automatic add_frame(input logic [31:0] l, input logic [31:0] r, input int nl, input int nr);
        frame_t f;
        f.l = l; f.r = r; f.nl = nl; f.nr = nr;
        tx_q.push_back(f);
        exp_q.push_back({exp_word(l, nl), exp_word(r, nr)});
    endtask

    task automatic bck_period(input logic ws, input logic din);
        ADC_BCK = 1'b0;
        ADC_WS  = ws;
        ADC_DIN = din;
        #($urandom_range(45, 65));
        ADC_BCK = 1'b1;
        #($urandom_range(45, 65));
    endtask

    // One-bit delay: the first period of a slot still carries the previous word's LSB.
    task automatic send_slot(input logic ws, input logic [31:0] val, input int n);
        bck_period(ws, last_bit);
        for (int i = n - 1; i >= 1; i--) bck_period(ws, val[i]);
        last_bit = val[0];
    endtask

    task automatic preamble();
        send_slot(1'b0, $urandom, 16);
        send_slot(1'b1, $urandom, 16);
    endtask

    task automatic send_tx(input int trail);
        foreach (tx_q[i]) begin
            send_slot(1'b0, tx_q[i].l, tx_q[i].nl);
            send_slot(1'b1, tx_q[i].r, tx_q[i].nr);
        end
        bck_period(1'b0, last_bit);
        for (int i = 1; i < trail; i++) bck_period(1'b0, 1'($urandom));
    endtask

    task automatic collect(input int n, input int max_cycles);
        int cyc = 0;
        while (got_q.size() < n && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) got_q.push_back({out_left, out_right});
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        ADC_BCK   = 1'b0;
        ADC_WS    = 1'b0;
        ADC_DIN   = 1'b0;
        last_bit  = 1'b0;
        tx_q.delete();
        exp_q.delete();
        got_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_left !== 16'h0) begin bad++; $display("[TB] FAIL reset_left: got %h want 0000", out_left); end
        total++; if (out_right !== 16'h0) begin bad++; $display("[TB] FAIL reset_right: got %h want 0000", out_right); end
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        add_frame(32'h8001, 32'h7FFE, 16, 16);
        for (int i = 0; i < 3; i++) add_frame($urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 16);
        preamble();
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL basic_prelock: got %b want 0", locked); end
        fork
            send_tx(16);
            collect(4, 8000);
        join
        total++; if (got_q.size() != 4) begin bad++; $display("[TB] FAIL basic_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL basic_frame%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL basic_locked: got %b want 1", locked); end
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL basic_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_mid_start();
        do_reset();
        rst_n = 1'b0;
        ADC_WS = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) bck_period(1'b1, 1'($urandom));
        last_bit = 1'($urandom);
        add_frame($urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 16);
        add_frame($urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 16);
        fork
            send_tx(16);
            collect(2, 6000);
        join
        repeat (20) @(negedge clk);
        total++; if (got_q.size() != 2) begin bad++; $display("[TB] FAIL mid_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 2; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL mid_frame%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_extra: got valid %b want 0", out_valid); end
    endtask

    task automatic test_word_len();
        int nl, nr;
        do_reset();
        out_ready = 1'b1;
        add_frame(32'hA5A5C3, $urandom & 32'hFFFFFF, 24, 24);
        add_frame(32'hFFF, $urandom & 32'hFFF, 12, 12);
        for (int i = 0; i < 3; i++) begin
            nl = int'($urandom_range(10, 32));
            nr = int'($urandom_range(10, 32));
            add_frame($urandom, $urandom, nl, nr);
        end
        preamble();
        fork
            send_tx(16);
            collect(5, 12000);
        join
        total++; if (got_q.size() != 5) begin bad++; $display("[TB] FAIL wlen_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL wlen_frame%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() >= 2) begin
            total++; if (got_q[0][31:16] !== 16'hA5A5) begin bad++; $display("[TB] FAIL wlen_trunc: got %h want a5a5", got_q[0][31:16]); end
            total++; if (got_q[1][31:16] !== 16'hFFF0) begin bad++; $display("[TB] FAIL wlen_pad: got %h want fff0", got_q[1][31:16]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        logic        stable;
        int          keep;
        do_reset();
        for (int i = 0; i < 6; i++) add_frame($urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 16);
        keep = (6 < DEPTH) ? 6 : DEPTH;
        preamble();
        send_tx(16);
        repeat (5) @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid: got %b want 1", out_valid); end
        total++; if (ovf !== (6 > DEPTH)) begin bad++; $display("[TB] FAIL bp_ovf: got %b want %b", ovf, (6 > DEPTH)); end
        held = {out_left, out_right};
        total++; if (held !== exp_q[0]) begin bad++; $display("[TB] FAIL bp_head: got %h want %h", held, exp_q[0]); end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({out_left, out_right} !== held) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("[TB] FAIL bp_stable: got %b want 1 (now %h%h)", stable, out_left, out_right); end
        set_ready(1'b1);
        collect(keep, 200);
        total++; if (got_q.size() != keep) begin bad++; $display("[TB] FAIL bp_count: got %0d want %0d", got_q.size(), keep); end
        for (int i = 0; i < got_q.size() && i < keep; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL bp_frame%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first;
        do_reset();
        for (int i = 0; i <= DEPTH; i++) add_frame($urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 16);
        preamble();
        foreach (tx_q[i]) begin
            send_slot(1'b0, tx_q[i].l, tx_q[i].nl);
            send_slot(1'b1, tx_q[i].r, tx_q[i].nr);
        end
        // Final period aligned to clk so the ready pulse lands on the push cycle of the last frame.
        ADC_BCK = 1'b0;
        ADC_WS  = 1'b0;
        ADC_DIN = last_bit;
        #50;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_full: got valid %b want 1", out_valid); end
        @(posedge clk);
        #2 ADC_BCK = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        first = {out_left, out_right};
        total++; if (first !== exp_q[0]) begin bad++; $display("[TB] FAIL b2b_head: got %h want %h", first, exp_q[0]); end
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (ovf !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ovf: got %b want 0", ovf); end
        set_ready(1'b1);
        collect(DEPTH, 200);
        total++; if (got_q.size() != DEPTH) begin bad++; $display("[TB] FAIL b2b_count: got %0d want %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            total++;
            if (got_q[i] !== exp_q[i + 1]) begin bad++; $display("[TB] FAIL b2b_frame%0d: got %h want %h", i, got_q[i], exp_q[i + 1]); end
        end
    endtask

    task automatic test_lock_loss();
        int keep;
        do_reset();
        add_frame($urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 16);
        add_frame($urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 16);
        keep = (2 < DEPTH) ? 2 : DEPTH;
        preamble();
        send_tx(16);
        repeat (200) @(negedge clk);
        total++; if (locked !== 1'b1) begin bad++; $display("[TB] FAIL lock_hold: got %b want 1", locked); end
        repeat (100) @(negedge clk);
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL lock_lost: got %b want 0", locked); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL lock_kept: got valid %b want 1", out_valid); end
        total++; if ({out_left, out_right} !== exp_q[0]) begin bad++; $display("[TB] FAIL lock_head: got %h%h want %h", out_left, out_right, exp_q[0]); end
        set_ready(1'b1);
        collect(keep, 200);
        total++; if (got_q.size() != keep) begin bad++; $display("[TB] FAIL lock_count: got %0d want %0d", got_q.size(), keep); end
        for (int i = 0; i < got_q.size() && i < keep; i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("[TB] FAIL lock_frame%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        add_frame(($urandom & 32'hFFFF) | 32'h1, ($urandom & 32'hFFFF) | 32'h1, 16, 16);
        preamble();
        send_tx(8);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre: got valid %b want 1", out_valid); end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_valid: got %b want 0", out_valid); end
        total++; if ({out_left, out_right} !== 32'h0) begin bad++; $display("[TB] FAIL arst_data: got %h%h want 0", out_left, out_right); end
        total++; if (locked !== 1'b0) begin bad++; $display("[TB] FAIL arst_locked: got %b want 0", locked); end
        @(negedge clk);
        rst_n = 1'b1;
        tx_q.delete();
        exp_q.delete();
        got_q.delete();
        add_frame($urandom & 32'hFFFF, $urandom & 32'hFFFF, 16, 16);
        out_ready = 1'b1;
        preamble();
        fork
            send_tx(16);
            collect(1, 4000);
        join
        total++; if (got_q.size() != 1) begin bad++; $display("[TB] FAIL arst_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("[TB] FAIL arst_frame: got %h want %h", got_q[0], exp_q[0]); end
        end
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting, buffer depth %0d", DEPTH);
        test_reset();
        test_basic();
        test_mid_start();
        test_word_len();
        test_backpressure();
        test_back_to_back();
        test_lock_loss();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
